// File: rtl/csram_port_arbiter_if.sv
// Signal bundle between two SRAM requesters, the shared SRAM macro port and
// the arbiter that sits between them. The arbiter takes the slave view; the
// requesters together with the SRAM macro take the master view.
interface csram_port_arbiter_if #(
    parameter int AW = 13
) ();

    // Requester 0
    logic          M0REQ;
    logic          M0LOCK;
    logic [AW-1:0] M0ADDR;
    logic [3:0]    M0WREN;
    logic [31:0]   M0WDATA;
    logic          M0GNT;
    logic          M0RVALID;
    logic [31:0]   M0RDATA;

    // Requester 1
    logic          M1REQ;
    logic          M1LOCK;
    logic [AW-1:0] M1ADDR;
    logic [3:0]    M1WREN;
    logic [31:0]   M1WDATA;
    logic          M1GNT;
    logic          M1RVALID;
    logic [31:0]   M1RDATA;

    // Shared SRAM port
    logic [AW-1:0] SRAMADDR;
    logic [3:0]    SRAMWREN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS;
    logic [31:0]   SRAMRDATA;

    modport slave (
        input  M0REQ, M0LOCK, M0ADDR, M0WREN, M0WDATA,
        input  M1REQ, M1LOCK, M1ADDR, M1WREN, M1WDATA,
        input  SRAMRDATA,
        output M0GNT, M0RVALID, M0RDATA,
        output M1GNT, M1RVALID, M1RDATA,
        output SRAMADDR, SRAMWREN, SRAMWDATA, SRAMCS
    );

    modport master (
        output M0REQ, M0LOCK, M0ADDR, M0WREN, M0WDATA,
        output M1REQ, M1LOCK, M1ADDR, M1WREN, M1WDATA,
        output SRAMRDATA,
        input  M0GNT, M0RVALID, M0RDATA,
        input  M1GNT, M1RVALID, M1RDATA,
        input  SRAMADDR, SRAMWREN, SRAMWDATA, SRAMCS
    );

endinterface

// File: rtl/csram_port_arbiter.sv
// Two-requester arbiter for a single-port SRAM. A lone requester is granted
// immediately; on a tie the previous owner keeps the port while it holds LOCK
// and has not used up its burst budget, otherwise ownership alternates.
// Grants and the SRAM port are combinational; read-valid is registered to
// line up with the SRAM's one-cycle read latency.
module csram_port_arbiter #(
    parameter int AW        = 13,
    parameter int MAX_BURST = 8
) (
    input  logic                SRAMHCLK,
    input  logic                SRAMHRESETn,
    csram_port_arbiter_if.slave bus
);

    localparam logic       OWNER_M0 = 1'b0;
    localparam logic       OWNER_M1 = 1'b1;
    localparam logic [3:0] CNT_MAX  = 4'(MAX_BURST);

    // Ownership history and read-valid pipeline
    logic          r_last;
    logic [3:0]    r_cnt;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;

    // Arbitration terms
    logic          w_both_req;
    logic          w_last_req;
    logic          w_last_lock;
    logic          w_honour_lock;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_last;
    logic          w_gnt_other;

    // Muxed SRAM port
    logic [AW-1:0] w_addr;
    logic [3:0]    w_wren;
    logic [31:0]   w_wdata;

    assign w_both_req    = bus.M0REQ & bus.M1REQ;
    assign w_last_req    = (r_last == OWNER_M1) ? bus.M1REQ  : bus.M0REQ;
    assign w_last_lock   = (r_last == OWNER_M1) ? bus.M1LOCK : bus.M0LOCK;
    assign w_honour_lock = w_last_req & w_last_lock & (r_cnt < CNT_MAX);

    // Pick the winner: lone requester always wins, ties go to a locked owner within budget, else round robin
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and a latch is never inferred.
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (SRAMHRESETn) begin
            if (w_both_req) begin
                if (w_honour_lock) begin
                    w_gnt0 = (r_last == OWNER_M0);
                    w_gnt1 = (r_last == OWNER_M1);
                end else begin
                    w_gnt0 = (r_last == OWNER_M1);
                    w_gnt1 = (r_last == OWNER_M0);
                end
            end else begin
                w_gnt0 = bus.M0REQ;
                w_gnt1 = bus.M1REQ;
            end
        end
    end

    assign w_gnt_last  = (r_last == OWNER_M1) ? w_gnt1 : w_gnt0;
    assign w_gnt_other = (r_last == OWNER_M1) ? w_gnt0 : w_gnt1;

    // Route the granted requester onto the SRAM port, all zeros when idle
    always_comb begin
        w_addr  = '0;
        w_wren  = '0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_addr  = bus.M0ADDR;
            w_wren  = bus.M0WREN;
            w_wdata = bus.M0WDATA;
        end else if (w_gnt1) begin
            w_addr  = bus.M1ADDR;
            w_wren  = bus.M1WREN;
            w_wdata = bus.M1WDATA;
        end
    end

    // Track the most recent owner and its run of consecutive grants
    always_ff @(posedge SRAMHCLK or negedge SRAMHRESETn) begin
        if (!SRAMHRESETn) begin
            // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
            r_last <= OWNER_M1;
            r_cnt  <= 4'd0;
        end else if (w_gnt_last) begin
            r_cnt  <= (r_cnt < CNT_MAX) ? r_cnt + 4'd1 : r_cnt;
        end else if (w_gnt_other) begin
            r_last <= ~r_last;
            r_cnt  <= 4'd1;
        end else begin
            r_cnt  <= 4'd0;
        end
    end

    // Flag read data one cycle after a read grant, in step with the SRAM output
    always_ff @(posedge SRAMHCLK or negedge SRAMHRESETn) begin
        if (!SRAMHRESETn) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0 & (bus.M0WREN == 4'b0000);
            r_m1_rvalid <= w_gnt1 & (bus.M1WREN == 4'b0000);
        end
    end

    assign bus.M0GNT     = w_gnt0;
    assign bus.M1GNT     = w_gnt1;
    assign bus.SRAMCS    = w_gnt0 | w_gnt1;
    assign bus.SRAMADDR  = w_addr;
    assign bus.SRAMWREN  = w_wren;
    assign bus.SRAMWDATA = w_wdata;
    assign bus.M0RVALID  = r_m0_rvalid;
    assign bus.M1RVALID  = r_m1_rvalid;
    assign bus.M0RDATA   = bus.SRAMRDATA;
    assign bus.M1RDATA   = bus.SRAMRDATA;

endmodule

// File: tb/tb_csram_port_arbiter.sv
// Bench for csram_port_arbiter: directed scenarios followed by a long random
// run, compared against a rule-level model of the arbiter and an SRAM copy.
module tb_csram_port_arbiter;

    localparam int AW        = 13;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << AW;

    logic SRAMHCLK    = 1'b0;
    logic SRAMHRESETn = 1'b1;

    always #5 SRAMHCLK = ~SRAMHCLK;

    csram_port_arbiter_if #(.AW(AW)) bus ();

    csram_port_arbiter #(
        .AW        (AW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .SRAMHCLK    (SRAMHCLK),
        .SRAMHRESETn (SRAMHRESETn),
        .bus         (bus)
    );

    typedef struct {
        int          who;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     sb [$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] sram_mem [DEPTH];
    bit          sram_written [DEPTH];
    int          m_last;
    int          m_run;
    int          wait_cnt [2];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] preload(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // SRAM macro: one-cycle read latency, byte-enabled writes
    always @(posedge SRAMHCLK) begin
        cyc <= cyc + 1;
        if (bus.SRAMCS) begin
            if (bus.SRAMWREN == 4'b0000) begin
                bus.SRAMRDATA <= sram_written[bus.SRAMADDR] ? sram_mem[bus.SRAMADDR]
                                                            : preload(bus.SRAMADDR);
            end else begin
                sram_mem[bus.SRAMADDR]     <= merge(sram_written[bus.SRAMADDR] ? sram_mem[bus.SRAMADDR]
                                                    : preload(bus.SRAMADDR),
                                                    bus.SRAMWREN, bus.SRAMWDATA);
                sram_written[bus.SRAMADDR] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbitration rules: -1 none, otherwise index of the winner
    function automatic int model_pick(input bit r0, input bit r1, input bit l0, input bit l1);
        bit lock_of_last;
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        lock_of_last = (m_last == 0) ? l0 : l1;
        if (lock_of_last && m_run < MAX_BURST) return m_last;
        return 1 - m_last;
    endfunction

    function automatic void model_commit(input int win);
        if (win < 0) begin
            m_run = 0;
        end else if (win == m_last) begin
            m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
        end else begin
            m_last = win;
            m_run  = 1;
        end
    endfunction

    // One arbitration cycle: drive, compare the combinational port, advance the model
    task automatic step(input bit r0, input bit r1, input bit l0, input bit l1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [3:0] w0, input logic [3:0] w1,
                        input logic [31:0] d0, input logic [31:0] d1, output int got);
        int            win;
        logic [AW-1:0] ea;
        logic [3:0]    ew;
        logic [31:0]   ed;
        @(posedge SRAMHCLK);
        #1;
        bus.M0REQ = r0;  bus.M0LOCK = l0;  bus.M0ADDR = a0;  bus.M0WREN = w0;  bus.M0WDATA = d0;
        bus.M1REQ = r1;  bus.M1LOCK = l1;  bus.M1ADDR = a1;  bus.M1WREN = w1;  bus.M1WDATA = d1;
        @(negedge SRAMHCLK);
        win = model_pick(r0, r1, l0, l1);
        got = bus.M0GNT ? 0 : (bus.M1GNT ? 1 : -1);
        check("gnt_onehot", 32'(bus.M0GNT & bus.M1GNT), 32'd0);
        check("gnt_m0", 32'(bus.M0GNT), 32'(win == 0));
        check("gnt_m1", 32'(bus.M1GNT), 32'(win == 1));
        ea = '0;  ew = '0;  ed = '0;
        if (win == 0) begin
            ea = a0;  ew = w0;  ed = d0;
        end else if (win == 1) begin
            ea = a1;  ew = w1;  ed = d1;
        end
        check("sram_cs", 32'(bus.SRAMCS), 32'(win >= 0));
        check("sram_addr", 32'(bus.SRAMADDR), 32'(ea));
        check("sram_wren", 32'(bus.SRAMWREN), 32'(ew));
        check("sram_wdata", bus.SRAMWDATA, ed);
        if (r0) begin
            wait_cnt[0] = (got == 0) ? 0 : wait_cnt[0] + 1;
            check("wait_m0", 32'(wait_cnt[0] <= MAX_BURST + 1), 32'd1);
        end else begin
            wait_cnt[0] = 0;
        end
        if (r1) begin
            wait_cnt[1] = (got == 1) ? 0 : wait_cnt[1] + 1;
            check("wait_m1", 32'(wait_cnt[1] <= MAX_BURST + 1), 32'd1);
        end else begin
            wait_cnt[1] = 0;
        end
        model_commit(win);
        if (win >= 0) begin
            if (ew == 4'b0000) sb.push_back('{win, model_mem[ea], cyc + 1});
            else               model_mem[ea] = merge(model_mem[ea], ew, ed);
        end
    endtask

    task automatic idle(output int got);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0, got);
    endtask

    // Hold reset with both requesters active; everything on the port must stay quiet
    task automatic apply_reset(input int n);
        #1;
        SRAMHRESETn = 1'b0;
        sb.delete();
        m_last      = 1;
        m_run       = 0;
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        bus.M0REQ = 1'b1;  bus.M0LOCK = 1'b1;  bus.M0ADDR = AW'(5);  bus.M0WREN = 4'hF;
        bus.M0WDATA = 32'h1234_5678;
        bus.M1REQ = 1'b1;  bus.M1LOCK = 1'b1;  bus.M1ADDR = AW'(9);  bus.M1WREN = 4'h3;
        bus.M1WDATA = 32'h8765_4321;
        repeat (n) begin
            @(negedge SRAMHCLK);
            check("rst_gnt", 32'({bus.M0GNT, bus.M1GNT}), 32'd0);
            check("rst_cs", 32'(bus.SRAMCS), 32'd0);
            check("rst_addr", 32'(bus.SRAMADDR), 32'd0);
            check("rst_wren", 32'(bus.SRAMWREN), 32'd0);
            check("rst_wdata", bus.SRAMWDATA, 32'd0);
            check("rst_rvalid", 32'({bus.M0RVALID, bus.M1RVALID}), 32'd0);
        end
        SRAMHRESETn = 1'b1;
        bus.M0REQ   = 1'b0;
        bus.M1REQ   = 1'b0;
    endtask

    // Read-response monitor: pops the scoreboard whenever a response is due
    initial begin : monitor
        rd_exp_t     e;
        bit          exp0;
        bit          exp1;
        logic [31:0] expd;
        forever begin
            @(negedge SRAMHCLK);
            exp0 = 1'b0;
            exp1 = 1'b0;
            expd = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e    = sb.pop_front();
                exp0 = (e.who == 0);
                exp1 = (e.who == 1);
                expd = e.data;
            end
            check("rvalid_m0", 32'(bus.M0RVALID), 32'(exp0));
            check("rvalid_m1", 32'(bus.M1RVALID), 32'(exp1));
            if (exp0) check("rdata_m0", bus.M0RDATA, expd);
            if (exp1) check("rdata_m1", bus.M1RDATA, expd);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of run expected finish by 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          got;
        bit          r0;
        bit          r1;
        bit          l0;
        bit          l1;
        logic [3:0]  w0;
        logic [3:0]  w1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = preload(AW'(i));
        bus.M0REQ = 1'b0;  bus.M0LOCK = 1'b0;  bus.M0ADDR = '0;  bus.M0WREN = '0;  bus.M0WDATA = '0;
        bus.M1REQ = 1'b0;  bus.M1LOCK = 1'b0;  bus.M1ADDR = '0;  bus.M1WREN = '0;  bus.M1WDATA = '0;
        apply_reset(3);

        // Tied reads after reset alternate starting with M0
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, AW'(16 + i), AW'(32 + i), 4'h0, 4'h0, 32'h0, 32'h0, got);
            check("tie_rr", 32'(got), 32'(i % 2));
        end
        idle(got);

        // M0 write then read back the same word
        step(1'b1, 1'b0, 1'b0, 1'b0, AW'(4), '0, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0, got);
        check("wr_gnt", 32'(got), 32'd0);
        check("wr_cs", 32'(bus.SRAMCS), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, AW'(4), '0, 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("rd_cs", 32'(bus.SRAMCS), 32'd1);
        check("wr_no_rvalid", 32'(bus.M0RVALID), 32'd0);
        idle(got);
        check("rd_rvalid", 32'(bus.M0RVALID), 32'd1);
        check("rd_data", bus.M0RDATA, 32'hDEAD_BEEF);
        idle(got);
        check("rd_rvalid_once", 32'(bus.M0RVALID), 32'd0);

        // M1 locked burst saturates at MAX_BURST, then round robin resumes
        apply_reset(2);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, AW'(40), 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("burst_first", 32'(got), 32'd1);
        for (int i = 0; i < MAX_BURST + 1; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, AW'(60 + i), AW'(41 + i), 4'h0, 4'h0, 32'h0, 32'h0, got);
            check("burst_seq", 32'(got), 32'((i < MAX_BURST - 1) ? 1 : ((i == MAX_BURST - 1) ? 0 : 1)));
        end
        idle(got);

        // Dropping REQ ends M0's run; the next unlocked tie goes to M1
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, AW'(70 + i), '0, 4'h0, 4'h0, 32'h0, 32'h0, got);
            check("lock_run", 32'(got), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("drop_none", 32'(got), 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 1'b0, AW'(80), AW'(81), 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("drop_tie", 32'(got), 32'd1);
        idle(got);

        // Reset right after an M0 read grant kills the pending read-valid
        step(1'b1, 1'b0, 1'b0, 1'b0, AW'(7), '0, 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("pre_rst_gnt", 32'(got), 32'd0);
        apply_reset(3);
        step(1'b1, 1'b1, 1'b0, 1'b0, AW'(90), AW'(91), 4'h0, 4'h0, 32'h0, 32'h0, got);
        check("post_rst_first", 32'(got), 32'd0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            l0 = ($urandom_range(0, 1) == 1);
            l1 = ($urandom_range(0, 1) == 1);
            w0 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            w1 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            step(r0, r1, l0, l1, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)),
                 w0, w1, $urandom, $urandom, got);
        end
        idle(got);
        idle(got);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
